// File: rtl/sound_pkg.sv
// sound_pkg: sound ids, FSM states, note half-periods, jingle lengths and note lookup
package sound_pkg;

    typedef enum logic [1:0] {SND_NONE, SND_START, SND_POINT, SND_WIN} snd_e;
    typedef enum logic [1:0] {IDLE, NOTE, GAP} state_e;

    localparam logic [17:0] NOTE_A4 = 18'd113636;
    localparam logic [17:0] NOTE_A5 = 18'd56818;
    localparam logic [17:0] NOTE_C5 = 18'd95556;
    localparam logic [17:0] NOTE_E5 = 18'd75842;
    localparam logic [17:0] NOTE_G5 = 18'd63776;
    localparam logic [17:0] NOTE_C6 = 18'd47778;

    localparam int LEN_START = 2;
    localparam int LEN_POINT = 1;
    localparam int LEN_WIN   = 4;

    function automatic logic [17:0] note_half(snd_e id, logic [1:0] i);
        return id == SND_START ? (i == 2'd0 ? NOTE_A4 : NOTE_A5) :
               id == SND_POINT ? NOTE_E5 :
               id == SND_WIN   ? (i == 2'd0 ? NOTE_C5 : i == 2'd1 ? NOTE_E5 :
                                  i == 2'd2 ? NOTE_G5 : NOTE_C6) : 18'd0;
    endfunction

    function automatic logic [1:0] last_idx(snd_e id);
        return id == SND_WIN   ? 2'(LEN_WIN - 1) :
               id == SND_START ? 2'(LEN_START - 1) : 2'(LEN_POINT - 1);
    endfunction

endpackage

// File: rtl/sound_sequencer_if.sv
// sound_sequencer_if: request/grant and tone bundle between game logic and the sequencer
interface sound_sequencer_if;
    logic        req_start;
    logic        req_point;
    logic        req_win;
    logic [2:0]  grant;
    logic        busy;
    logic [1:0]  sound_id;
    logic [17:0] tone_half;
    logic        music;
    modport master (output req_start, req_point, req_win,
                    input grant, busy, sound_id, tone_half, music);
    modport slave  (input req_start, req_point, req_win,
                    output grant, busy, sound_id, tone_half, music);
endinterface

// File: rtl/tone_gen.sv
// tone_gen: square-wave divider toggling music every half_period cycles, silent at 0
module tone_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] half_period,
    output logic        music
);

    logic [17:0] div;
    logic [17:0] hp_q;

    // reload and restart low on any new note, otherwise count down and toggle at zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div   <= '0;
            hp_q  <= '0;
            music <= 1'b0;
        end else begin
            hp_q <= half_period;
            if (half_period == 18'd0) begin
                div   <= '0;
                music <= 1'b0;
            end else if (half_period != hp_q) begin
                div   <= half_period - 18'd1;
                music <= 1'b0;
            end else if (div == 18'd0) begin
                div   <= half_period - 18'd1;
                music <= ~music;
            end else begin
                div <= div - 18'd1;
            end
        end
    end

endmodule

// File: rtl/sound_sequencer.sv
// sound_sequencer: arbitrates jingle requests and sequences notes into tone_gen (SOUND_PREEMPT_EN enables preemption)
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int NOTE_TICKS = 12_500_000,
    parameter int GAP_TICKS  = 1_250_000
) (
    input  logic             clk,
    input  logic             rst,
    sound_sequencer_if.slave bus
);

    localparam logic [23:0] NOTE_LOAD = 24'(NOTE_TICKS - 1);
    localparam logic [23:0] GAP_LOAD  = 24'(GAP_TICKS - 1);

    state_e      state;
    snd_e        sound_id;
    snd_e        req_id;
    logic [1:0]  idx;
    logic [23:0] cnt;
    logic [2:0]  grant;
    logic        busy;
    logic [17:0] tone_half;
    logic        music;
    logic        take;

    // fixed priority win > point > start; losers are simply dropped
    always_comb req_id = bus.req_win ? SND_WIN : bus.req_point ? SND_POINT :
                         bus.req_start ? SND_START : SND_NONE;

`ifdef SOUND_PREEMPT_EN
    // idle has sound_id NONE, so any request wins there; while busy only strictly higher ones
    always_comb take = req_id > sound_id;
`else
    // requests are only accepted when idle
    always_comb take = state == IDLE && req_id != SND_NONE;
`endif

    // sequencing FSM: grant/restart on take, otherwise NOTE -> GAP -> next NOTE or IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sound_id  <= SND_NONE;
            idx       <= '0;
            cnt       <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            tone_half <= '0;
        end else begin
            grant <= '0;
            if (take) begin
                grant     <= {req_id == SND_WIN, req_id == SND_POINT, req_id == SND_START};
                busy      <= 1'b1;
                sound_id  <= req_id;
                idx       <= '0;
                state     <= NOTE;
                tone_half <= note_half(req_id, 2'd0);
                cnt       <= NOTE_LOAD;
            end else begin
                case (state)
                    NOTE: begin
                        if (cnt == 24'd0) begin
                            state     <= GAP;
                            tone_half <= '0;
                            cnt       <= GAP_LOAD;
                        end else begin
                            cnt <= cnt - 24'd1;
                        end
                    end
                    GAP: begin
                        if (cnt != 24'd0) begin
                            cnt <= cnt - 24'd1;
                        end else if (idx == last_idx(sound_id)) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            sound_id <= SND_NONE;
                        end else begin
                            idx       <= idx + 2'd1;
                            state     <= NOTE;
                            tone_half <= note_half(sound_id, idx + 2'd1);
                            cnt       <= NOTE_LOAD;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    tone_gen u_tone (
        .clk         (clk),
        .rst         (rst),
        .half_period (tone_half),
        .music       (music)
    );

    assign bus.grant     = grant;
    assign bus.busy      = busy;
    assign bus.sound_id  = sound_id;
    assign bus.tone_half = tone_half;
    assign bus.music     = music;

endmodule

// File: tb/tb_sound_sequencer.sv
// tb_sound_sequencer: scoreboard bench for sound_sequencer and tone_gen with short note timing
module tb_sound_sequencer;

    typedef struct {
        logic [2:0]  g;
        logic [1:0]  id;
        logic [17:0] th;
        int          c;
    } gexp_t;

    typedef struct {
        logic [17:0] th;
        int          c;
    } texp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [17:0] hp = '0;
    logic tg_music;
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    gexp_t q_grant[$];
    texp_t q_tone[$];
    int    q_busy[$];
    int    q_tg[$];

    sound_sequencer_if bus();

    sound_sequencer #(.NOTE_TICKS(100), .GAP_TICKS(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    tone_gen u_tg (
        .clk         (clk),
        .rst         (rst),
        .half_period (hp),
        .music       (tg_music)
    );

    always #5 clk = ~clk;

    // cycle stamp shared by stimulus and monitor
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic [2:0] m, output int n);
        @(negedge clk);
        {bus.req_win, bus.req_point, bus.req_start} = m;
        n = cyc;
    endtask

    task automatic release_req();
        @(negedge clk);
        {bus.req_win, bus.req_point, bus.req_start} = 3'b000;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push_jingle(input logic [2:0] g, input int id, input int n);
        logic [17:0] nt[4];
        int len;
        case (id)
            1: begin nt = '{18'd113636, 18'd56818, 18'd0, 18'd0}; len = 2; end
            2: begin nt = '{18'd75842, 18'd0, 18'd0, 18'd0}; len = 1; end
            default: begin nt = '{18'd95556, 18'd75842, 18'd63776, 18'd47778}; len = 4; end
        endcase
        q_grant.push_back('{g, 2'(id), nt[0], n + 1});
        for (int k = 0; k < len; k++) begin
            q_tone.push_back('{nt[k], n + 1 + 110 * k});
            q_tone.push_back('{18'd0, n + 101 + 110 * k});
        end
        q_busy.push_back(n + 1 + 110 * len);
    endtask

    logic [17:0] prev_tone = '0;
    logic        prev_busy = 1'b0;
    logic        prev_tg = 1'b0;
    gexp_t       ge;
    texp_t       te;
    int          bc;

    // monitor: pops the scoreboard whenever the DUT grants, changes tone or drops busy
    always @(negedge clk) begin
        if (bus.grant != 3'b000) begin
            if (q_grant.size() == 0) chk("unexpected_grant", bus.grant, 0);
            else begin
                ge = q_grant.pop_front();
                chk("grant", bus.grant, ge.g);
                chk("grant_sound_id", bus.sound_id, ge.id);
                chk("grant_tone_half", bus.tone_half, ge.th);
                chk("grant_cycle", cyc, ge.c);
                chk("grant_busy", bus.busy, 1);
            end
        end
        if (bus.tone_half != prev_tone) begin
            if (q_tone.size() == 0) chk("unexpected_tone", bus.tone_half, prev_tone);
            else begin
                te = q_tone.pop_front();
                chk("tone_half", bus.tone_half, te.th);
                chk("tone_cycle", cyc, te.c);
            end
        end
        if (prev_busy && !bus.busy) begin
            if (q_busy.size() == 0) chk("unexpected_busy_fall", cyc, -1);
            else begin
                bc = q_busy.pop_front();
                chk("busy_fall_cycle", cyc, bc);
            end
        end
        if (tg_music != prev_tg) begin
            if (q_tg.size() == 0) chk("unexpected_tg_toggle", cyc, -1);
            else begin
                bc = q_tg.pop_front();
                chk("tg_toggle_cycle", cyc, bc);
            end
        end
        prev_tone = bus.tone_half;
        prev_busy = bus.busy;
        prev_tg   = tg_music;
    end

    initial begin
        int n, m, c;
        {bus.req_win, bus.req_point, bus.req_start} = 3'b000;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        // reset mid-jingle
        drive(3'b001, n);
        q_grant.push_back('{3'b001, 2'd1, 18'd113636, n + 1});
        q_tone.push_back('{18'd113636, n + 1});
        release_req();
        wait_cyc(n + 30);
        chk("pre_rst_busy", bus.busy, 1);
        @(posedge clk);
        #2;
        c = cyc;
        q_tone.push_back('{18'd0, c});
        q_busy.push_back(c);
        rst = 1'b0;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_grant", bus.grant, 0);
        chk("rst_sound_id", bus.sound_id, 0);
        chk("rst_tone_half", bus.tone_half, 0);
        chk("rst_music", bus.music, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        // single POINT jingle, then another right as busy falls
        drive(3'b010, n);
        push_jingle(3'b010, 2, n);
        release_req();
        wait_cyc(n + 50);
        chk("point_music_running", bus.music, (50 - 1) / 75842 % 2);
        wait_cyc(n + 110);
        drive(3'b010, m);
        push_jingle(3'b010, 2, m);
        release_req();
        wait_cyc(m + 112);
        // WIN and START together, then START 50 cycles into WIN
        drive(3'b101, n);
        push_jingle(3'b100, 3, n);
        release_req();
        wait_cyc(n + 49);
        drive(3'b001, m);
        release_req();
        wait_cyc(n + 445);
        chk("idle_after_win", bus.busy, 0);
`ifdef SOUND_PREEMPT_EN
        drive(3'b001, n);
        q_grant.push_back('{3'b001, 2'd1, 18'd113636, n + 1});
        q_tone.push_back('{18'd113636, n + 1});
        release_req();
        wait_cyc(n + 49);
        drive(3'b100, m);
        push_jingle(3'b100, 3, m);
        release_req();
        wait_cyc(m + 445);
`endif
        // standalone tone generator with half period 4
        @(negedge clk);
        hp = 18'd4;
        c = cyc;
        q_tg.push_back(c + 5);
        q_tg.push_back(c + 9);
        q_tg.push_back(c + 13);
        q_tg.push_back(c + 15);
        wait_cyc(c + 14);
        chk("tg_high_before_stop", tg_music, 1);
        hp = 18'd0;
        wait_cyc(c + 30);
        chk("tg_silent", tg_music, 0);
        chk("q_grant_empty", q_grant.size(), 0);
        chk("q_tone_empty", q_tone.size(), 0);
        chk("q_busy_empty", q_busy.size(), 0);
        chk("q_tg_empty", q_tg.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        vectors++;
        miscompares++;
        $display("FAIL timeout: bench did not complete within 20000 cycles");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
